// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor: the controller state
//   encoding and the default operand width.
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  // Default operand/result width in bits.
  localparam int SERIAL_SUB_WIDTH_DEF = 8;

  // Controller states. The encoding is fixed so that waveforms and any
  // external state probes read the same across builds.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_sub_pkg

// File: rtl/fs.sv
// -----------------------------------------------------------------------------
// fs
//   One-bit full subtractor cell: computes a - b - c.
//
// Ports
//   a       in   minuend bit
//   b       in   subtrahend bit
//   c       in   borrow-in
//   diff    out  difference bit, a ^ b ^ c
//   borrow  out  borrow-out, (~a & b) | (~(a ^ b) & c)
// -----------------------------------------------------------------------------
module fs (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ c;
  assign borrow = (~a & b) | (~(a ^ b) & c);

endmodule : fs

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor. Operands are accepted through a
//   valid/ready handshake, a - b is computed LSB-first one bit per clock
//   through a single fs cell with a registered borrow, and the difference
//   and final borrow are presented through a valid/ready output handshake.
//
//   Latency is WIDTH cycles from the acceptance edge to out_valid. Throughput
//   is at best one operation per WIDTH+2 cycles (accept, WIDTH run edges,
//   output handshake); there is no same-cycle turnaround.
//
// Parameters
//   WIDTH       operand/result width, 2..32
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   in_a/in_b valid
//   in_ready    out  idle and able to accept operands (state decode)
//   in_a        in   minuend
//   in_b        in   subtrahend
//   out_valid   out  out_diff/out_borrow valid (state decode)
//   out_ready   in   consumer accepts the result
//   out_diff    out  (in_a - in_b) mod 2^WIDTH, registered
//   out_borrow  out  1 iff in_a < in_b (unsigned), registered
//   out_ovf     out  signed overflow, registered
//                    (port exists only when SERIAL_SUB_OVF_EN is defined)
//
// Build options
//   SERIAL_SUB_OVF_EN   adds the out_ovf port and its overflow flag logic.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   a_q,      a_d;       // minuend, shifts right
  logic [WIDTH-1:0]   b_q,      b_d;       // subtrahend, shifts right
  logic [WIDTH-1:0]   res_q,    res_d;     // difference, filled from the MSB
  logic               borrow_q, borrow_d;  // borrow between bit positions
  logic [CNT_W-1:0]   cnt_q,    cnt_d;     // index of the bit being processed
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_q,    ovf_d;
`endif

  logic fs_diff;
  logic fs_borrow;

  // The single arithmetic cell: always fed from the low end of the operand
  // shift registers and the registered borrow.
  fs u_fs (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .c      (borrow_q),
    .diff   (fs_diff),
    .borrow (fs_borrow)
  );

  // NOTE: every signal assigned here gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = {fs_diff, res_q[WIDTH-1:1]};
        borrow_d = fs_borrow;
        if (cnt_q == CNT_LAST) begin
          // Last bit: a_q[0]/b_q[0] now hold the original operand MSBs.
          // The counter is parked at zero rather than allowed to run on.
          cnt_d   = '0;
          state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_q[0] != b_q[0]) & (fs_diff != a_q[0]);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Result registers are not written here, so they hold while the
        // consumer applies backpressure.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  // NOTE: reset clears the whole datapath, so a run interrupted by reset
  // leaves no stale partial difference on out_diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);

  // The result register and the borrow register double as the output
  // registers: after the final run edge they hold the finished difference
  // and the final borrow, and nothing writes them again until the next
  // acceptance.
  assign out_diff   = res_q;
  assign out_borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign out_ovf    = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor. An 8-bit instance covers
//   directed cases, backpressure, reset during a run and random operands;
//   a 4-bit instance is swept over every operand pair with random
//   output backpressure. Expected values come from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // 8-bit instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_borrow8;
  logic [7:0] in_a8, in_b8, out_diff8;
`ifdef SERIAL_SUB_OVF_EN
  logic       out_ovf8;
`endif

  // 4-bit instance
  logic       in_valid4, in_ready4, out_valid4, out_ready4, out_borrow4;
  logic [3:0] in_a4, in_b4, out_diff4;
`ifdef SERIAL_SUB_OVF_EN
  logic       out_ovf4;
`endif

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .in_a       (in_a8),
    .in_b       (in_b8),
    .out_valid  (out_valid8),
    .out_ready  (out_ready8),
    .out_diff   (out_diff8),
    .out_borrow (out_borrow8)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .out_ovf    (out_ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .in_a       (in_a4),
    .in_b       (in_b4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .out_diff   (out_diff4),
    .out_borrow (out_borrow4)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .out_ovf    (out_ovf4)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: unsigned difference, unsigned borrow, signed overflow.
  function automatic int model_diff(input int w, input int a, input int b);
    return (a - b) & ((1 << w) - 1);
  endfunction

  function automatic logic model_borrow(input int a, input int b);
    return (a < b);
  endfunction

  function automatic logic model_ovf(input int w, input int a, input int b);
    int sa, sb, d;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    d  = sa - sb;
    return (d > (1 << (w - 1)) - 1) || (d < -(1 << (w - 1)));
  endfunction

  // One complete 8-bit operation: accept, measure latency, hold the result
  // for `hold` cycles under backpressure while pulsing in_valid, then
  // complete the output handshake.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold);
    int t;
    int exp_d;
    t = 0;
    while (!in_ready8 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready8 before accept", in_ready8, 1);
    in_a8 = a; in_b8 = b; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    t = 0;
    while (!out_valid8 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("latency8", t, 8);
    exp_d = model_diff(8, int'(a), int'(b));
    for (int i = 0; i < hold; i++) begin
      check("hold diff8", out_diff8, exp_d);
      check("hold borrow8", out_borrow8, model_borrow(int'(a), int'(b)));
      check("hold in_ready8", in_ready8, 0);
      check("hold out_valid8", out_valid8, 1);
      // These pulses must be ignored outside IDLE.
      in_valid8 = 1'b1; in_a8 = 8'($urandom); in_b8 = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    check("diff8", out_diff8, exp_d);
    check("borrow8", out_borrow8, model_borrow(int'(a), int'(b)));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf8", out_ovf8, model_ovf(8, int'(a), int'(b)));
`endif
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("in_ready8 after handshake", in_ready8, 1);
    check("out_valid8 after handshake", out_valid8, 0);
  endtask

  // One 4-bit operation with random backpressure.
  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    int t;
    t = 0;
    while (!in_ready4 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    in_a4 = a; in_b4 = b; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    t = 0;
    while (!out_valid4 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t != 4) check("latency4", t, 4);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    check("sweep diff4", out_diff4, model_diff(4, int'(a), int'(b)));
    check("sweep borrow4", out_borrow4, model_borrow(int'(a), int'(b)));
`ifdef SERIAL_SUB_OVF_EN
    check("sweep ovf4", out_ovf4, model_ovf(4, int'(a), int'(b)));
`endif
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; in_a8 = '0; in_b8 = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; in_a4 = '0; in_b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready8", in_ready8, 1);
    check("reset out_valid8", out_valid8, 0);
    check("reset diff8", out_diff8, 0);
    check("reset borrow8", out_borrow8, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf8", out_ovf8, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    op8(8'h5A, 8'h3C, 0);
    op8(8'h00, 8'h01, 0);
    op8(8'hA5, 8'hA5, 0);
    op8(8'hFF, 8'h00, 1);
    op8(8'h00, 8'hFF, 2);
    // Backpressure with ignored in_valid pulses
    op8(8'h37, 8'h92, 5);
`ifdef SERIAL_SUB_OVF_EN
    op8(8'h80, 8'h01, 0);
    op8(8'h7F, 8'hFF, 0);
    op8(8'h05, 8'h03, 0);
`endif

    // Reset in the middle of a run
    in_a8 = 8'hFF; in_b8 = 8'h01; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun rst out_valid8", out_valid8, 0);
    check("midrun rst in_ready8", in_ready8, 1);
    check("midrun rst diff8", out_diff8, 0);
    check("midrun rst borrow8", out_borrow8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op8(8'h10, 8'h20, 0);

    // Random operands with random backpressure
    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    // Exhaustive 4-bit sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op4(4'(a), 4'(b));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_subtractor
